// File: rtl/sar_pkg.sv
// rtl/sar_pkg.sv - shared types and constants for the SAR result collector
package sar_pkg;

    localparam int DATA_W = 8;
    localparam int ACC_W  = DATA_W + 3;

    localparam int ERR_TMO  = 0;
    localparam int ERR_SPUR = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        CONV  = 2'd2
    } sar_state_t;

    // Sample index of the last sample in a group of 2^osr samples.
    function automatic logic [2:0] grp_last_idx(input logic [1:0] osr);
        case (osr)
            2'd0:    return 3'd0;
            2'd1:    return 3'd1;
            2'd2:    return 3'd3;
            default: return 3'd7;
        endcase
    endfunction

endpackage

// File: rtl/sar_result_fifo.sv
// rtl/sar_result_fifo.sv - small result FIFO with registered first-word-fall-through head
module sar_result_fifo #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [DATA_W-1:0]            push_data,
    input  logic                         pop,
    output logic [DATA_W-1:0]            head_data,
    output logic                         head_valid,
    output logic [$clog2(FIFO_DEPTH):0]  level
);

    localparam int PW = $clog2(FIFO_DEPTH);

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     rd_ptr_n;
    logic [PW:0]       level_n;
    logic              push_ok;
    logic              pop_ok;

    always_comb begin
        push_ok  = push && (level != (PW+1)'(FIFO_DEPTH));
        pop_ok   = pop && (level != '0);
        rd_ptr_n = pop_ok ? rd_ptr + 1'b1 : rd_ptr;
        level_n  = level;
        if (push_ok && !pop_ok) begin
            level_n = level + 1'b1;
        end else if (!push_ok && pop_ok) begin
            level_n = level - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // The head register bypasses the array when the entry being written lands at the new read pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            head_data  <= '0;
            head_valid <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            rd_ptr     <= rd_ptr_n;
            level      <= level_n;
            head_valid <= (level_n != '0);
            if (level_n == '0) begin
                head_data <= '0;
            end else if (push_ok && (wr_ptr == rd_ptr_n)) begin
                head_data <= push_data;
            end else begin
                head_data <= mem[rd_ptr_n];
            end
        end
    end

endmodule

// File: rtl/sar_result_collector.sv
// rtl/sar_result_collector.sv - SAR conversion sequencer, oversampling averager and result FIFO (SAR_ROUND_EN selects rounding)
module sar_result_collector #(
    parameter int DATA_W      = sar_pkg::DATA_W,
    parameter int FIFO_DEPTH  = 4,
    parameter int TIMEOUT_CYC = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         run,
    input  logic [1:0]                   osr_log2,
    output logic                         cnvst,
    input  logic [DATA_W-1:0]            sar_in,
    input  logic                         eoc_in,
    output logic [DATA_W-1:0]            res_data,
    output logic                         res_valid,
    input  logic                         res_ready,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
    output logic [1:0]                   err_stat,
    input  logic                         err_clr
);

    import sar_pkg::*;

    localparam int AW = DATA_W + (ACC_W - sar_pkg::DATA_W);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;
    localparam int TW = $clog2(TIMEOUT_CYC);

    sar_state_t        state;
    sar_state_t        state_n;
    logic [TW-1:0]     tmo_cnt;
    logic [AW-1:0]     acc;
    logic [AW-1:0]     sum;
    logic [2:0]        cnt;
    logic [1:0]        osr_lat;
    logic              tmo_hit;
    logic              sample_ok;
    logic              grp_done;
    logic              push;
    logic              overflow;
    logic [DATA_W-1:0] grp_res;
    logic [1:0]        err_nxt;

    always_comb begin
        state_n = state;
        tmo_hit = 1'b0;
        case (state)
            IDLE:  if (run && (fifo_level < LW'(FIFO_DEPTH))) state_n = START;
            START: state_n = CONV;
            CONV: begin
                if (eoc_in) begin
                    state_n = IDLE;
                end else if (tmo_cnt == TW'(TIMEOUT_CYC - 1)) begin
                    state_n = IDLE;
                    tmo_hit = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

`ifdef SAR_ROUND_EN
    localparam int RW = AW + 1;
    logic [RW-1:0] rnd;
`endif

    always_comb begin
        sample_ok = (state == CONV) && eoc_in;
        grp_done  = (cnt == grp_last_idx(osr_lat));
        push      = sample_ok && grp_done;
        overflow  = push && (fifo_level == LW'(FIFO_DEPTH));
        sum       = acc + AW'(sar_in);
`ifdef SAR_ROUND_EN
        rnd = '0;
        if (osr_lat == 2'd0) begin
            grp_res = DATA_W'(sum);
        end else begin
            rnd     = (RW'(sum) + (RW'(1) << (osr_lat - 2'd1))) >> osr_lat;
            grp_res = (rnd > RW'({DATA_W{1'b1}})) ? {DATA_W{1'b1}} : DATA_W'(rnd);
        end
`else
        grp_res = DATA_W'(sum >> osr_lat);
`endif
        err_nxt = err_clr ? 2'b00 : err_stat;
        if (tmo_hit || overflow) err_nxt[ERR_TMO] = 1'b1;
        if (eoc_in && (state != CONV)) err_nxt[ERR_SPUR] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnvst    <= 1'b0;
            tmo_cnt  <= '0;
            acc      <= '0;
            cnt      <= '0;
            osr_lat  <= '0;
            err_stat <= '0;
        end else begin
            state    <= state_n;
            cnvst    <= (state_n == START);
            err_stat <= err_nxt;
            if (state == START) begin
                tmo_cnt <= '0;
                if (cnt == '0) osr_lat <= osr_log2;
            end else if (state == CONV) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
            // A timed-out conversion drops the whole partial group.
            if (sample_ok) begin
                if (grp_done) begin
                    acc <= '0;
                    cnt <= '0;
                end else begin
                    acc <= sum;
                    cnt <= cnt + 1'b1;
                end
            end else if (tmo_hit) begin
                acc <= '0;
                cnt <= '0;
            end
        end
    end

    sar_result_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_data  (grp_res),
        .pop        (res_ready),
        .head_data  (res_data),
        .head_valid (res_valid),
        .level      (fifo_level)
    );

endmodule

// File: tb/tb_sar_result_collector.sv
// tb/tb_sar_result_collector.sv - directed self-checking bench for sar_result_collector
module tb_sar_result_collector;

    localparam int DATA_W      = 8;
    localparam int FIFO_DEPTH  = 4;
    localparam int TIMEOUT_CYC = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              run;
    logic [1:0]        osr_log2;
    logic              cnvst;
    logic [DATA_W-1:0] sar_in;
    logic              eoc_in;
    logic [DATA_W-1:0] res_data;
    logic              res_valid;
    logic              res_ready;
    logic [2:0]        fifo_level;
    logic [1:0]        err_stat;
    logic              err_clr;

    logic eoc_model;
    logic eoc_spur;
    assign eoc_in = eoc_model | eoc_spur;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int cnv_cnt = 0;
    int cnv_cyc = 0;
    int sar_dly = 10;
    bit sar_en  = 1'b1;
    bit busy    = 1'b0;
    int dly     = 0;
    logic [DATA_W-1:0] sar_q [$];

    sar_result_collector #(
        .DATA_W      (DATA_W),
        .FIFO_DEPTH  (FIFO_DEPTH),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .osr_log2   (osr_log2),
        .cnvst      (cnvst),
        .sar_in     (sar_in),
        .eoc_in     (eoc_in),
        .res_data   (res_data),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .fifo_level (fifo_level),
        .err_stat   (err_stat),
        .err_clr    (err_clr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // SAR block model: eoc with the next queued word sar_dly cycles after it sees cnvst.
    always @(negedge clk) begin
        eoc_model = 1'b0;
        if (rst) begin
            busy = 1'b0;
        end else if (busy) begin
            dly = dly - 1;
            if (dly == 0) begin
                eoc_model = 1'b1;
                sar_in    = (sar_q.size() > 0) ? sar_q.pop_front() : '0;
                busy      = 1'b0;
            end
        end
        if (!rst && cnvst) begin
            cnv_cnt = cnv_cnt + 1;
            cnv_cyc = cyc;
            if (sar_en) begin
                busy = 1'b1;
                dly  = sar_dly;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic run_group(input string tag, input logic [1:0] osr, input int n, input logic [7:0] exp);
        int base;
        base     = cnv_cnt;
        osr_log2 = osr;
        sar_dly  = 3;
        run      = 1'b1;
        for (int i = 0; i < 200 && cnv_cnt != base + n; i++) step();
        run = 1'b0;
        check({tag, "_starts"}, cnv_cnt - base, n);
        for (int i = 0; i < 20 && !res_valid; i++) step();
        repeat (3) step();
        check({tag, "_level"}, fifo_level, 1);
        check({tag, "_data"}, res_data, exp);
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        check({tag, "_drained"}, fifo_level, 0);
    endtask

    initial begin
        int base;
        int c0;
        rst = 1'b1; run = 1'b0; osr_log2 = 2'd0; res_ready = 1'b0;
        err_clr = 1'b0; eoc_spur = 1'b0; sar_in = '0;
        repeat (2) step();
        check("rst_cnvst", cnvst, 0);
        check("rst_valid", res_valid, 0);
        check("rst_data", res_data, 0);
        check("rst_level", fifo_level, 0);
        check("rst_err", err_stat, 0);
        rst = 1'b0;
        step();

        // single conversion, no averaging
        sar_q.push_back(8'hA5);
        sar_dly = 10;
        base = cnv_cnt;
        run = 1'b1;
        step();
        run = 1'b0;
        for (int i = 0; i < 40 && !res_valid; i++) step();
        check("single_valid", res_valid, 1);
        check("single_latency", cyc - cnv_cyc, 11);
        check("single_data", res_data, 8'hA5);
        check("single_level", fifo_level, 1);
        repeat (5) step();
        check("single_one_cnvst", cnv_cnt - base, 1);
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        check("single_pop_valid", res_valid, 0);

        // averaging groups
        sar_q = '{8'd10, 8'd11, 8'd12, 8'd14};
`ifdef SAR_ROUND_EN
        run_group("avg4", 2'd2, 4, 8'd12);
`else
        run_group("avg4", 2'd2, 4, 8'd11);
`endif
        sar_q = '{8'd200, 8'd255};
`ifdef SAR_ROUND_EN
        run_group("avg2", 2'd1, 2, 8'd228);
`else
        run_group("avg2", 2'd1, 2, 8'd227);
`endif
        sar_q = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd9};
`ifdef SAR_ROUND_EN
        run_group("avg8", 2'd3, 8, 8'd5);
`else
        run_group("avg8", 2'd3, 8, 8'd4);
`endif
        sar_q = '{8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255};
        run_group("avg8_max", 2'd3, 8, 8'd255);

        // back-pressure: FIFO fills, then one pop frees one slot
        sar_q = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5};
        osr_log2 = 2'd0;
        sar_dly = 2;
        base = cnv_cnt;
        run = 1'b1;
        repeat (80) step();
        check("bp_starts", cnv_cnt - base, 4);
        check("bp_full", fifo_level, 4);
        check("bp_head", res_data, 1);
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        check("bp_level3", fifo_level, 3);
        check("bp_head2", res_data, 2);
        for (int i = 0; i < 10 && cnv_cnt != base + 5; i++) step();
        run = 1'b0;
        check("bp_restart", cnv_cnt - base, 5);
        for (int i = 0; i < 30 && fifo_level != 3'd4; i++) step();
        check("bp_refull", fifo_level, 4);
        res_ready = 1'b1;
        for (int k = 2; k <= 5; k++) begin
            check("bp_drain", res_data, k);
            step();
        end
        res_ready = 1'b0;
        check("bp_empty_level", fifo_level, 0);
        check("bp_empty_valid", res_valid, 0);
        check("bp_no_err", err_stat, 0);

        // timeout: SAR never answers
        sar_en = 1'b0;
        base = cnv_cnt;
        run = 1'b1;
        for (int i = 0; i < 10 && cnv_cnt == base; i++) step();
        c0 = cnv_cyc;
        for (int i = 0; i < 60 && err_stat == 2'b00; i++) step();
        check("tmo_err", err_stat, 2'b01);
        check("tmo_cycle", cyc - c0, TIMEOUT_CYC + 1);
        for (int i = 0; i < 5 && cnv_cnt != base + 2; i++) step();
        run = 1'b0;
        check("tmo_retry", cnv_cnt - base, 2);
        repeat (40) step();
        check("tmo_no_push", fifo_level, 0);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        check("tmo_clr", err_stat, 0);
        sar_en = 1'b1;

        // spurious eoc while idle, and set-over-clear priority
        eoc_spur = 1'b1;
        step();
        eoc_spur = 1'b0;
        check("spur_err", err_stat, 2'b10);
        check("spur_no_push", fifo_level, 0);
        check("spur_no_valid", res_valid, 0);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        check("spur_clr", err_stat, 0);
        err_clr = 1'b1;
        eoc_spur = 1'b1;
        step();
        err_clr = 1'b0;
        eoc_spur = 1'b0;
        check("spur_set_wins", err_stat, 2'b10);

        // asynchronous reset mid-conversion with two results queued
        sar_q = '{8'h33, 8'h44, 8'h55};
        sar_dly = 10;
        osr_log2 = 2'd0;
        base = cnv_cnt;
        run = 1'b1;
        for (int i = 0; i < 100 && fifo_level != 3'd2; i++) step();
        check("arst_pre_level", fifo_level, 2);
        for (int i = 0; i < 10 && cnv_cnt != base + 3; i++) step();
        repeat (3) step();
        #1 rst = 1'b1;
        #1;
        check("arst_cnvst", cnvst, 0);
        check("arst_valid", res_valid, 0);
        check("arst_data", res_data, 0);
        check("arst_level", fifo_level, 0);
        check("arst_err", err_stat, 0);
        run = 1'b0;
        repeat (2) step();
        rst = 1'b0;
        sar_q.delete();
        repeat (3) step();
        check("arst_after_level", fifo_level, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
